// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit and receive blocks.
package uart_pkg;

    localparam int UART_DATA_W = 8;
    localparam int UART_DIV_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef struct packed {
        logic [UART_DIV_W-1:0] div;
        logic                  parity_en;
        logic                  parity_odd;
        logic                  stop2;
    } frame_cfg_t;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// FIFO-to-transmitter handshake: the FIFO presents a byte, the transmitter paces pops with tx_busy.
interface uart_tx_ctrl_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W
) ();

    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_valid;
    logic                  tx_busy;

    modport master (
        output fifo_data,
        output fifo_valid,
        input  tx_busy
    );

    modport slave (
        input  fifo_data,
        input  fifo_valid,
        output tx_busy
    );

endinterface

// File: rtl/uart_baud_gen.sv
// Loadable down-counter marking the last cycle of each bit period (period = div + 1 cycles).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV_W = UART_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             bit_end
);

    logic [DIV_W-1:0] count;

    // Holds at zero once expired so an unreloaded counter never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= div;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign bit_end = (count == '0);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: pops bytes from the TX FIFO and serialises start, data, optional parity and stop bits.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = UART_DATA_W,
    parameter int DIV_W      = UART_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_ctrl_if.slave    fifo_if,
    input  logic             tx_en,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             parity_en,
    input  logic             parity_odd,
    input  logic             stop2,
    output logic             tx,
    output logic             tx_done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    tx_state_e             state;
    tx_state_e             next_state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_d;
    logic [IDX_W-1:0]      bit_idx_q;
    logic [IDX_W-1:0]      bit_idx_d;
    logic                  parity_q;
    logic                  parity_d;
    logic                  stop_cnt_q;
    logic                  stop_cnt_d;
    frame_cfg_t            cfg_q;
    frame_cfg_t            cfg_d;
    logic                  pop;
    logic                  bit_end;
    logic                  baud_load;
    logic [DIV_W-1:0]      load_div;
    logic                  tx_d;
    logic                  tx_done_d;
    logic                  busy;

    assign pop = (state == IDLE) && tx_en && fifo_if.fifo_valid;

    // The pop edge loads the live divisor because the latched copy only lands on that same edge.
    assign baud_load = pop || ((state != IDLE) && bit_end);
    assign load_div  = pop ? baud_div : cfg_q.div;

    uart_baud_gen #(
        .DIV_W(DIV_W)
    ) u_baud_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (baud_load),
        .div    (load_div),
        .bit_end(bit_end)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (pop) next_state = START;
            end
            START: begin
                if (bit_end) next_state = DATA;
            end
            DATA: begin
                if (bit_end && (bit_idx_q == LAST_IDX)) begin
                    next_state = cfg_q.parity_en ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) next_state = STOP;
            end
            STOP: begin
                if (bit_end && (stop_cnt_q || !cfg_q.stop2)) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        parity_d   = parity_q;
        stop_cnt_d = stop_cnt_q;
        cfg_d      = cfg_q;
        if (pop) begin
            shift_d    = fifo_if.fifo_data;
            bit_idx_d  = '0;
            parity_d   = 1'b0;
            stop_cnt_d = 1'b0;
            cfg_d      = '{div: baud_div, parity_en: parity_en, parity_odd: parity_odd, stop2: stop2};
        end else if ((state == DATA) && bit_end) begin
            shift_d   = {1'b0, shift_q[DATA_WIDTH-1:1]};
            parity_d  = parity_q ^ shift_q[0];
            bit_idx_d = bit_idx_q + 1'b1;
        end else if ((state == STOP) && bit_end) begin
            stop_cnt_d = 1'b1;
        end
    end

    // tx is registered, so its next value follows the state and shift contents being entered.
    always_comb begin
        busy      = !((state == IDLE) && tx_en);
        tx_done_d = (state == STOP) && (next_state == IDLE);
        tx_d      = 1'b1;
        case (next_state)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d ^ cfg_q.parity_odd;
            default: tx_d = 1'b1;
        endcase
    end

    assign fifo_if.tx_busy = busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q    <= '0;
            bit_idx_q  <= '0;
            parity_q   <= 1'b0;
            stop_cnt_q <= 1'b0;
            cfg_q      <= '0;
            tx         <= 1'b1;
            tx_done    <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            parity_q   <= parity_d;
            stop_cnt_q <= stop_cnt_d;
            cfg_q      <= cfg_d;
            tx         <= tx_d;
            tx_done    <= tx_done_d;
        end
    end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that drains the TX FIFO and serialises each byte onto the `tx` line as an asynchronous frame: start bit, 8 data bits LSB-first, optional parity, then 1 or 2 stop bits. It sits between the TX FIFO and the pad. It drives the FIFO's `tx_busy` input to pace dequeues, and consumes `buff_out`/`data_valid`. Baud rate and frame format come from CSR-driven inputs and are sampled once per frame.

## Interface
- `DATA_WIDTH`, 8 — byte width; fixed frame data length.
- `DIV_W`, 16 — width of the baud divisor.
- `clk` in 1 — system clock.
- `rst_n` in 1 — asynchronous active-low reset.
- `fifo_data` in DATA_WIDTH — FIFO `buff_out`; valid only when `fifo_valid`=1.
- `fifo_valid` in 1 — FIFO `data_valid`; pop occurs on this cycle's rising edge.
- `tx_busy` out 1 — to FIFO; 0 only when idle and enabled.
- `tx_en` in 1 — transmitter enable.
- `baud_div` in DIV_W — bit period = `baud_div`+1 clk cycles.
- `parity_en` in 1 — insert a parity bit.
- `parity_odd` in 1 — 1 = odd parity, 0 = even.
- `stop2` in 1 — 1 = two stop bits.
- `tx` out 1 — serial line, idle high.
- `tx_done` out 1 — one-cycle pulse at the end of the last stop bit.

## Operation
- States (`tx_state_e`): IDLE, START, DATA, PARITY, STOP.
- `tx_busy` = !(state==IDLE && tx_en). It is combinational from registered state and `tx_en`, has no path from `fifo_valid`, and so creates no loop.
- **IDLE:** `tx`=1. On `fifo_valid`=1:
  - latch `fifo_data` into the shift register;
  - latch `baud_div`, `parity_en`, `parity_odd`, `stop2` into frame config;
  - clear bit index and parity accumulator;
  - go to START.
  - `fifo_valid` seen outside IDLE is ignored. It cannot occur, because `tx_busy`=1 there.
- **START:** `tx`=0 for one bit period, then DATA.
- **DATA:** `tx`=shift[0].
  - At each bit end: shift right, XOR the bit into the parity accumulator, increment the index.
  - After bit 7: go to PARITY if parity is enabled, else STOP.
- **PARITY:** `tx` = accumulator XOR `parity_odd`, for one bit period, then STOP.
- **STOP:** `tx`=1 for 1 or 2 bit periods per latched `stop2`.
  - At the final bit end: pulse `tx_done` and return to IDLE.
- **Bit timing:** a down-counter loads the latched divisor on every state entry and counts to 0. The bit ends when the counter is 0.
  - `baud_div`=0 gives 1-cycle bits, which is legal.
  - Arithmetic is DIV_W unsigned, with no wrap beyond the reload.
- **Config changes mid-frame** have no effect until the next pop.
- **`tx_en` deasserted mid-frame:** the current frame completes. No new pop occurs while `tx_en`=0.
- **Reset (any time, including mid-frame):**
  - state=IDLE, `tx`=1, `tx_done`=0, `tx_busy`=!`tx_en`;
  - the shift register, counter and config registers clear to 0;
  - an in-flight byte is lost.

## Timing
- `tx` and `tx_done` are registered outputs.
- Pop on edge N (`fifo_valid` high in cycle N-1): `tx` falls at edge N. `tx_busy` is high from edge N onward, so there is exactly one pop per frame.
- Frame length = (1+8+P+S)·(`baud_div`+1) cycles, with P∈{0,1} and S∈{1,2}.
- Back-to-back frames with a non-empty FIFO: `tx_done` pulses in the cycle after the last stop bit (cycle T, state IDLE, `tx_busy`=0). The pop occurs on edge T+1 and the next start bit begins there.
  - This gives exactly one idle-high cycle between frames.
  - Throughput is one frame per frame-length+1 cycles.
- FIFO empty in IDLE: the controller stays IDLE with `tx`=1 indefinitely.

## Structure
- Package `uart_pkg`:
  - `tx_state_e` enum;
  - `UART_DATA_W`=8;
  - `UART_DIV_W`=16;
  - `frame_cfg_t` struct {div, parity_en, parity_odd, stop2}.
- Sub-module `uart_baud_gen`:
  - loadable DIV_W down-counter;
  - inputs `load`, `div`;
  - output `bit_end`.
  - It is reused later by the RX side, which instantiates it with a 16x oversample divisor.
- The top module holds the FSM, shift register, parity accumulator and stop counter.

## Test plan
- **Reset idle:** assert `rst_n`=0 mid-DATA at bit 3 → `tx`=1 in the same cycle, state IDLE, with no `tx_done`. After release with FIFO empty, `tx` stays 1 for 100 cycles.
- **Single byte 8N1:** 0xA5, `baud_div`=3 → `tx` = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles. `tx_done` pulses once; 40 cycles in total.
- **Parity/stop:** 0x07 even parity with `stop2`=1 at `baud_div`=0 → `tx` sequence 0,1,1,1,0,0,0,0,0,1,1,1 (12 cycles). Repeat with odd parity → parity bit 0.
- **Back-to-back:** FIFO preloaded with 0x11, 0x22, 0x33 → exactly 3 pops and 3 `tx_done` pulses, with one idle-high cycle between frames. The bytes appear in order.
- **Enable gating:** `tx_en`=0 with a non-empty FIFO → `tx_busy`=1, no pop, and `tx`=1. Dropping `tx_en` mid-frame lets that frame finish, and the FIFO count stays unchanged afterwards.
- **Config latch:** change `baud_div` from 3 to 7 during DATA of frame 1 → frame 1 keeps 4-cycle bits and frame 2 uses 8-cycle bits.
